// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and defaults for the round-robin memory arbiter.
//   state_e    : arbiter FSM states (IDLE -> BUSY -> RESP -> IDLE)
//   DEF_*      : default parameter values for mem_rr_arbiter
//   next_ptr() : round-robin pointer advance with wrap
// -----------------------------------------------------------------------------
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_ADDR_WIDTH = 10;
    localparam int DEF_WIDTH      = 16;
    localparam int DEF_TIMEOUT    = 16;

    // The requester just served becomes the lowest priority for the next pick.
    function automatic int next_ptr(input int grant, input int num_req);
        return (grant + 1 >= num_req) ? 0 : grant + 1;
    endfunction

endpackage

// File: rtl/mem_rr_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector: finds the first set request bit starting
// at the pointer and searching upward with wrap.
//   req_i       : request vector
//   ptr_i       : highest-priority requester index
//   any_o       : at least one request present
//   grant_oh_o  : one-hot winner
//   grant_idx_o : binary index of the winner
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic               any_o,
    output logic [NUM_REQ-1:0] grant_oh_o,
    output logic [PTR_W-1:0]   grant_idx_o
);

    always_comb begin : pick
        int idx;
        // NOTE: every output gets a default before any conditional assignment,
        // otherwise the no-request path would infer latches.
        any_o       = 1'b0;
        grant_oh_o  = '0;
        grant_idx_o = '0;
        idx         = 0;
        // Walk from the farthest offset back to the pointer so the nearest
        // requester (lowest offset) is the last, and therefore winning, write.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(ptr_i) + k) % NUM_REQ;
            if (req_i[idx]) begin
                any_o           = 1'b1;
                grant_oh_o      = '0;
                grant_oh_o[idx] = 1'b1;
                grant_idx_o     = PTR_W'(idx);
            end
        end
    end

endmodule

// File: rtl/mem_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mem_rr_arbiter
// Shares one single-port valid/ready memory between NUM_REQ requesters using
// round-robin arbitration. One command is latched per transfer; completion is
// a one-cycle one-hot pulse on req_ready_o with read data on req_rdata_o.
//
// Ports:
//   clk_i, rst_i        clock; asynchronous active-low reset
//   req_valid_i         per-requester request, held until its req_ready_o
//   req_wr_rd_i         per-requester 1 = write, 0 = read
//   req_addr_i          packed addresses, requester r at [r*ADDR_WIDTH +: ADDR_WIDTH]
//   req_wdata_i         packed write data, requester r at [r*WIDTH +: WIDTH]
//   req_ready_o         one-hot completion pulse
//   req_rdata_o         read data, valid with req_ready_o (0 for writes)
//   req_err_o           timeout flag, valid with req_ready_o
//   mem_valid_o, mem_wr_rd_o, mem_addr_o, mem_wdata_o   command to memory
//   mem_ready_i, mem_rdata_i                            response from memory
//
// Configuration: define MEM_ARB_TIMEOUT_EN to abort a BUSY transfer after
// TIMEOUT cycles without mem_ready_i (reported via req_err_o). Without it the
// arbiter waits indefinitely and req_err_o is tied low.
// -----------------------------------------------------------------------------
module mem_rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int WIDTH      = DEF_WIDTH,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ-1:0]            req_wr_rd_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
    input  logic [NUM_REQ*WIDTH-1:0]      req_wdata_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic [WIDTH-1:0]              req_rdata_o,
    output logic                          req_err_o,
    output logic                          mem_valid_o,
    output logic                          mem_wr_rd_o,
    output logic [ADDR_WIDTH-1:0]         mem_addr_o,
    output logic [WIDTH-1:0]              mem_wdata_o,
    input  logic                          mem_ready_i,
    input  logic [WIDTH-1:0]              mem_rdata_i
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Unpacked views of the per-requester command fields.
    logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
    logic [WIDTH-1:0]      wdata_arr [NUM_REQ];

    always_comb begin
        for (int r = 0; r < NUM_REQ; r++) begin
            addr_arr[r]  = req_addr_i[r*ADDR_WIDTH +: ADDR_WIDTH];
            wdata_arr[r] = req_wdata_i[r*WIDTH +: WIDTH];
        end
    end

    state_e                state_q,     state_d;
    logic [PTR_W-1:0]      ptr_q,       ptr_d;
    logic [NUM_REQ-1:0]    grant_oh_q,  grant_oh_d;
    logic [PTR_W-1:0]      grant_idx_q, grant_idx_d;
    logic                  mem_valid_q, mem_valid_d;
    logic                  mem_wr_rd_q, mem_wr_rd_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q,  mem_addr_d;
    logic [WIDTH-1:0]      mem_wdata_q, mem_wdata_d;
    logic [NUM_REQ-1:0]    req_ready_q, req_ready_d;
    logic [WIDTH-1:0]      req_rdata_q, req_rdata_d;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0]      cnt_q,       cnt_d;
    logic                  req_err_q,   req_err_d;
`endif

    logic                  pick_any;
    logic [NUM_REQ-1:0]    pick_oh;
    logic [PTR_W-1:0]      pick_idx;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_pick (
        .req_i       (req_valid_i),
        .ptr_i       (ptr_q),
        .any_o       (pick_any),
        .grant_oh_o  (pick_oh),
        .grant_idx_o (pick_idx)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_oh_d  = grant_oh_q;
        grant_idx_d = grant_idx_q;
        mem_valid_d = mem_valid_q;
        mem_wr_rd_d = mem_wr_rd_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        // Response outputs are pulses: they fall back to 0 unless set below.
        req_ready_d = '0;
        req_rdata_d = '0;
`ifdef MEM_ARB_TIMEOUT_EN
        cnt_d       = cnt_q;
        req_err_d   = 1'b0;
`endif

        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_oh_d  = pick_oh;
                    grant_idx_d = pick_idx;
                    mem_valid_d = 1'b1;
                    mem_wr_rd_d = req_wr_rd_i[pick_idx];
                    mem_addr_d  = addr_arr[pick_idx];
                    mem_wdata_d = wdata_arr[pick_idx];
                    state_d     = BUSY;
`ifdef MEM_ARB_TIMEOUT_EN
                    cnt_d       = '0;
`endif
                end
            end

            BUSY: begin
                // The command is committed: req_valid_i is no longer looked at.
                if (mem_ready_i) begin
                    mem_valid_d = 1'b0;
                    req_ready_d = grant_oh_q;
                    req_rdata_d = mem_wr_rd_q ? '0 : mem_rdata_i;
                    state_d     = RESP;
                end
`ifdef MEM_ARB_TIMEOUT_EN
                // Count reaches TIMEOUT-1 in the TIMEOUT-th BUSY cycle.
                else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    mem_valid_d = 1'b0;
                    req_ready_d = grant_oh_q;
                    req_err_d   = 1'b1;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end

            RESP: begin
                ptr_d   = PTR_W'(next_ptr(int'(grant_idx_q), NUM_REQ));
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values computed above.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            grant_oh_q  <= '0;
            grant_idx_q <= '0;
            mem_valid_q <= 1'b0;
            mem_wr_rd_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            req_ready_q <= '0;
            req_rdata_q <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            cnt_q       <= '0;
            req_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_oh_q  <= grant_oh_d;
            grant_idx_q <= grant_idx_d;
            mem_valid_q <= mem_valid_d;
            mem_wr_rd_q <= mem_wr_rd_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            req_ready_q <= req_ready_d;
            req_rdata_q <= req_rdata_d;
`ifdef MEM_ARB_TIMEOUT_EN
            cnt_q       <= cnt_d;
            req_err_q   <= req_err_d;
`endif
        end
    end

    assign req_ready_o = req_ready_q;
    assign req_rdata_o = req_rdata_q;
    assign mem_valid_o = mem_valid_q;
    assign mem_wr_rd_o = mem_wr_rd_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
`ifdef MEM_ARB_TIMEOUT_EN
    assign req_err_o   = req_err_q;
`else
    assign req_err_o   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_rr_arbiter
// Self-checking bench for mem_rr_arbiter. The bench plays both the requesters
// and the memory; a reference model (priority pointer + memory array) predicts
// the winner, the command on the memory port and the returned data.
// Define MEM_ARB_TIMEOUT_EN to also exercise the timeout abort.
// -----------------------------------------------------------------------------
module tb_mem_rr_arbiter;

    localparam int N       = 4;
    localparam int AW      = 10;
    localparam int DW      = 16;
    localparam int TIMEOUT = 16;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [N-1:0]      req_valid_i;
    logic [N-1:0]      req_wr_rd_i;
    logic [N*AW-1:0]   req_addr_i;
    logic [N*DW-1:0]   req_wdata_i;
    logic [N-1:0]      req_ready_o;
    logic [DW-1:0]     req_rdata_o;
    logic              req_err_o;
    logic              mem_valid_o;
    logic              mem_wr_rd_o;
    logic [AW-1:0]     mem_addr_o;
    logic [DW-1:0]     mem_wdata_o;
    logic              mem_ready_i;
    logic [DW-1:0]     mem_rdata_i;

    always #5 clk_i = ~clk_i;

    mem_rr_arbiter #(
        .NUM_REQ    (N),
        .ADDR_WIDTH (AW),
        .WIDTH      (DW),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_wr_rd_i (req_wr_rd_i),
        .req_addr_i  (req_addr_i),
        .req_wdata_i (req_wdata_i),
        .req_ready_o (req_ready_o),
        .req_rdata_o (req_rdata_o),
        .req_err_o   (req_err_o),
        .mem_valid_o (mem_valid_o),
        .mem_wr_rd_o (mem_wr_rd_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_ready_i (mem_ready_i),
        .mem_rdata_i (mem_rdata_i)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state.
    int            ptr_m;
    logic [DW-1:0] mem_m [0:(1<<AW)-1];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int r, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid_i[r]          = 1'b1;
        req_wr_rd_i[r]          = wr;
        req_addr_i[r*AW +: AW]  = a;
        req_wdata_i[r*DW +: DW] = d;
    endtask

    // Winner = first pending requester at or after the priority pointer.
    function automatic int model_pick();
        for (int k = 0; k < N; k++) begin
            if (req_valid_i[(ptr_m + k) % N]) return (ptr_m + k) % N;
        end
        return -1;
    endfunction

    function automatic int oh_index(input logic [N-1:0] v);
        if ($countones(v) != 1) return -1;
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // One full transfer, entered at a falling edge while the arbiter is IDLE
    // and at least one request is pending; returns at a falling edge in IDLE.
    task automatic serve(input int delay, input bit keep, input bit drop_in_busy,
                         output int obs_idx, output logic [DW-1:0] obs_rdata);
        int            w;
        bit            wr;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [DW-1:0] exp_rd;
        w  = model_pick();
        wr = req_wr_rd_i[w];
        a  = req_addr_i[w*AW +: AW];
        d  = req_wdata_i[w*DW +: DW];

        @(negedge clk_i);
        check("mem_valid_rise", mem_valid_o, 1);
        check("mem_wr_rd", mem_wr_rd_o, wr);
        check("mem_addr", mem_addr_o, a);
        if (wr) check("mem_wdata", mem_wdata_o, d);
        check("no_early_ready", req_ready_o, 0);
        if (drop_in_busy) req_valid_i[w] = 1'b0;

        repeat (delay) begin
            @(negedge clk_i);
            check("busy_hold_valid", mem_valid_o, 1);
            check("busy_hold_addr", mem_addr_o, a);
            check("busy_no_ready", req_ready_o, 0);
        end

        exp_rd      = wr ? '0 : mem_m[a];
        mem_rdata_i = wr ? DW'($urandom) : mem_m[a];
        if (wr) mem_m[a] = d;
        mem_ready_i = 1'b1;

        @(negedge clk_i);
        mem_ready_i = 1'b0;
        mem_rdata_i = DW'($urandom);
        obs_idx     = oh_index(req_ready_o);
        obs_rdata   = req_rdata_o;
        check("ready_onehot", req_ready_o, onehot(w));
        check("rdata", req_rdata_o, exp_rd);
        check("err_clear", req_err_o, 0);
        check("mem_valid_drop", mem_valid_o, 0);
        ptr_m = (w + 1) % N;
        if (!keep) req_valid_i[w] = 1'b0;

        @(negedge clk_i);
        check("ready_pulse_end", req_ready_o, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        int            idx;
        logic [DW-1:0] rd;
        int            cnt [N];
        int            first_idx;

        for (int i = 0; i < (1 << AW); i++) mem_m[i] = DW'($urandom);
        ptr_m       = 0;
        rst_i       = 1'b0;
        req_valid_i = '0;
        req_wr_rd_i = '0;
        req_addr_i  = '0;
        req_wdata_i = '0;
        mem_ready_i = 1'b0;
        mem_rdata_i = '0;

        // Reset state.
        repeat (2) @(negedge clk_i);
        check("rst_mem_valid", mem_valid_o, 0);
        check("rst_mem_addr", mem_addr_o, 0);
        check("rst_req_ready", req_ready_o, 0);
        check("rst_req_rdata", req_rdata_o, 0);
        check("rst_req_err", req_err_o, 0);
        rst_i = 1'b1;
        @(negedge clk_i);
        check("idle_no_valid", mem_valid_o, 0);

        // Single write from requester 0, memory ready after 2 cycles.
        set_req(0, 1'b1, 10'h010, 16'hBEEF);
        serve(2, 1'b0, 1'b0, idx, rd);
        check("write_grant", idx, 0);

        // Readback from requester 1.
        set_req(1, 1'b0, 10'h010, 16'h0000);
        serve(0, 1'b0, 1'b0, idx, rd);
        check("readback_grant", idx, 1);
        check("readback_data", rd, 16'hBEEF);

        // Reset in the middle of a BUSY transfer from requester 3.
        set_req(3, 1'b1, 10'h3AA, 16'h1234);
        @(negedge clk_i);
        check("pre_rst_busy", mem_valid_o, 1);
        #2 rst_i = 1'b0;
        #1;
        check("async_rst_mem_valid", mem_valid_o, 0);
        check("async_rst_mem_wr_rd", mem_wr_rd_o, 0);
        check("async_rst_mem_addr", mem_addr_o, 0);
        check("async_rst_mem_wdata", mem_wdata_o, 0);
        check("async_rst_req_ready", req_ready_o, 0);
        ptr_m = 0;
        for (int r = 0; r < N; r++) set_req(r, r[0], AW'(10'h100 + r), DW'(16'hA000 + r));
        @(negedge clk_i);
        rst_i = 1'b1;

        // Fairness: all requesters pending continuously.
        for (int r = 0; r < N; r++) cnt[r] = 0;
        first_idx = -1;
        for (int t = 0; t < 5; t++) begin
            serve($urandom_range(0, 2), 1'b1, 1'b0, idx, rd);
            if (t == 0) first_idx = idx;
            if (t < N && idx >= 0) cnt[idx]++;
            if (t == 4) check("fair_wrap_grant", idx, first_idx);
        end
        check("fair_first_ptr0", first_idx, 0);
        for (int r = 0; r < N; r++) check($sformatf("fair_count_%0d", r), cnt[r], 1);
        req_valid_i = '0;

        // Dropping valid during BUSY does not cancel the transfer.
        set_req(2, 1'b0, 10'h010, 16'h0000);
        serve(3, 1'b0, 1'b1, idx, rd);
        check("drop_valid_grant", idx, 2);

        // Randomized traffic: pending requests hold, new ones arrive at random.
        for (int t = 0; t < 40; t++) begin
            for (int r = 0; r < N; r++) begin
                if (!req_valid_i[r] && $urandom_range(0, 1) == 1) begin
                    logic [AW-1:0] a;
                    case ($urandom_range(0, 3))
                        0:       a = 10'h010;
                        1:       a = 10'h020;
                        2:       a = 10'h030;
                        default: a = AW'($urandom);
                    endcase
                    set_req(r, $urandom_range(0, 1) == 1, a, DW'($urandom));
                end
            end
            if (req_valid_i == '0) set_req($urandom_range(0, N - 1), 1'b0, 10'h020, 16'h0000);
            serve($urandom_range(0, 3), 1'b0, 1'b0, idx, rd);
        end

`ifdef MEM_ARB_TIMEOUT_EN
        // Timeout: memory never answers.
        begin
            int w;
            req_valid_i = '0;
            set_req(0, 1'b0, 10'h020, 16'h0000);
            w = model_pick();
            @(negedge clk_i);
            check("to_busy", mem_valid_o, 1);
            repeat (TIMEOUT - 1) begin
                @(negedge clk_i);
                check("to_hold_valid", mem_valid_o, 1);
                check("to_no_ready", req_ready_o, 0);
            end
            @(negedge clk_i);
            check("to_ready", req_ready_o, onehot(w));
            check("to_err", req_err_o, 1);
            check("to_rdata", req_rdata_o, 0);
            check("to_mem_valid", mem_valid_o, 0);
            req_valid_i[w] = 1'b0;
            ptr_m          = (w + 1) % N;
            mem_ready_i    = 1'b1;
            mem_rdata_i    = 16'hDEAD;
            @(negedge clk_i);
            mem_ready_i = 1'b0;
            check("to_late_ready_ignored", req_ready_o, 0);
            check("to_err_pulse_end", req_err_o, 0);
            @(negedge clk_i);
            check("to_back_idle", mem_valid_o, 0);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
